// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
//
// ID/EX pipeline register with built-in load-use hazard detection. It sits
// directly upstream of the EX forwarding unit.
//
// What it does:
//   - Registers the decoded operands and control of the instruction in ID into EX.
//   - Detects when the load now in EX writes a register that the instruction in
//     ID reads. When that happens it holds PC and IF/ID, and it feeds
//     LOAD_USE_BUBBLES all-zero bubbles into EX.
//   - Squashes the instruction in ID when a taken branch in EX asserts EX_Flush.
//
// Parameters:
//   REG_ADDR_W        width of the register-number fields
//   DATA_W            width of the operand and immediate data
//   LOAD_USE_BUBBLES  bubbles inserted per load-use hazard (1..3)
//
// Ports:
//   clk, rst_n                    clock; synchronous active-low reset
//   EX_Flush                      branch taken in EX, squash ID
//   IF_ID_Reg_Rs / IF_ID_Reg_Rt   source registers of the instruction in ID
//   ID_Reg_Rd                     destination register (RegDst already applied)
//   ID_RegWrite, ID_MemRead       decoded write enable and load flag
//   ID_Ctrl                       {MemWrite, MemtoReg, ALUSrc, ALUOp[2:0]}
//   ID_Read_Data1/2, ID_Imm       operand data and sign-extended immediate
//   ID_EX_*                       registered copies of the above, seen by EX
//   PC_Write, IF_ID_Write         1 = the upstream stage may advance
//   Hazard_Stall                  1 = a stall is in effect this cycle
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
  parameter int REG_ADDR_W       = 32,
  parameter int DATA_W           = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EX_Flush,
  input  logic [REG_ADDR_W-1:0] IF_ID_Reg_Rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_Reg_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Reg_Rd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic [5:0]            ID_Ctrl,
  input  logic [DATA_W-1:0]     ID_Read_Data1,
  input  logic [DATA_W-1:0]     ID_Read_Data2,
  input  logic [DATA_W-1:0]     ID_Imm,
  output logic [REG_ADDR_W-1:0] ID_EX_Reg_Rs,
  output logic [REG_ADDR_W-1:0] ID_EX_Reg_Rt,
  output logic [REG_ADDR_W-1:0] ID_EX_Reg_Rd,
  output logic                  ID_EX_RegWrite,
  output logic                  ID_EX_MemRead,
  output logic [5:0]            ID_EX_Ctrl,
  output logic [DATA_W-1:0]     ID_EX_Read_Data1,
  output logic [DATA_W-1:0]     ID_EX_Read_Data2,
  output logic [DATA_W-1:0]     ID_EX_Imm,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  Hazard_Stall
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // The counter is 2 bits wide because LOAD_USE_BUBBLES is limited to 1..3.
  // It holds the number of bubbles still owed after the first one.
  localparam logic [1:0] EXTRA_BUBBLES = 2'(LOAD_USE_BUBBLES - 1);

  state_t          state_r;
  logic [1:0]      count_r;
  logic            hazard_s;
  logic            stall_s;
  logic            capture_s;

  // Load-use detection. It is only evaluated in RUN.
  // Register 0 is hard-wired and never causes a hazard.
  always_comb begin
    hazard_s = 1'b0;
    if ((state_r == ST_RUN) && ID_EX_MemRead &&
        (ID_EX_Reg_Rt != {REG_ADDR_W{1'b0}}) &&
        ((ID_EX_Reg_Rt == IF_ID_Reg_Rs) || (ID_EX_Reg_Rt == IF_ID_Reg_Rt))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Stall / capture decision. A flush always wins over a stall, because the
  // instruction being held in ID is discarded anyway.
  always_comb begin
    stall_s   = 1'b0;
    capture_s = 1'b0;
    if (EX_Flush) begin
      stall_s   = 1'b0;
      capture_s = 1'b0;
    end else if (hazard_s || (state_r == ST_STALL)) begin
      stall_s   = 1'b1;
      capture_s = 1'b0;
    end else begin
      stall_s   = 1'b0;
      capture_s = 1'b1;
    end
  end

  // Upstream handshake. While reset is held, the front end is free to run.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    Hazard_Stall = 1'b0;
    if (!rst_n) begin
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      Hazard_Stall = 1'b0;
    end else begin
      PC_Write     = !stall_s;
      IF_ID_Write  = !stall_s;
      Hazard_Stall = stall_s;
    end
  end

  // Stall sequencer. A flush or a reset returns it to RUN at once.
  // With a single bubble it never leaves RUN, because the bubble clears
  // ID_EX_MemRead and so the hazard cannot re-trigger.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      count_r <= 2'd0;
    end else if (EX_Flush) begin
      state_r <= ST_RUN;
      count_r <= 2'd0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (hazard_s && (LOAD_USE_BUBBLES > 1)) begin
            state_r <= ST_STALL;
            count_r <= EXTRA_BUBBLES;
          end else begin
            state_r <= ST_RUN;
            count_r <= 2'd0;
          end
        end
        ST_STALL: begin
          count_r <= count_r - 2'd1;
          if (count_r == 2'd1) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_STALL;
          end
        end
        default: begin
          state_r <= ST_RUN;
          count_r <= 2'd0;
        end
      endcase
    end
  end

  // ID/EX pipeline register. A bubble zeroes every field.
  // The zero Rd and the cleared RegWrite keep the forwarding unit inert.
  always_ff @(posedge clk) begin
    if (!rst_n || !capture_s) begin
      ID_EX_Reg_Rs     <= {REG_ADDR_W{1'b0}};
      ID_EX_Reg_Rt     <= {REG_ADDR_W{1'b0}};
      ID_EX_Reg_Rd     <= {REG_ADDR_W{1'b0}};
      ID_EX_RegWrite   <= 1'b0;
      ID_EX_MemRead    <= 1'b0;
      ID_EX_Ctrl       <= 6'd0;
      ID_EX_Read_Data1 <= {DATA_W{1'b0}};
      ID_EX_Read_Data2 <= {DATA_W{1'b0}};
      ID_EX_Imm        <= {DATA_W{1'b0}};
    end else begin
      ID_EX_Reg_Rs     <= IF_ID_Reg_Rs;
      ID_EX_Reg_Rt     <= IF_ID_Reg_Rt;
      ID_EX_Reg_Rd     <= ID_Reg_Rd;
      ID_EX_RegWrite   <= ID_RegWrite;
      ID_EX_MemRead    <= ID_MemRead;
      ID_EX_Ctrl       <= ID_Ctrl;
      ID_EX_Read_Data1 <= ID_Read_Data1;
      ID_EX_Read_Data2 <= ID_Read_Data2;
      ID_EX_Imm        <= ID_Imm;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
//
// Drives two instances from one shared input stream:
//   - dut_a with LOAD_USE_BUBBLES=1
//   - dut_b with LOAD_USE_BUBBLES=3
//
// A behavioural model tracks, for each instance, the expected EX contents and
// the number of bubbles still owed. Every cycle, on the falling edge, the
// outputs of both instances are compared against this model.
//
// Directed scenarios add hand-computed literal expectations on top of that.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EX_Flush;
  logic [31:0] id_rs, id_rt, id_rd;
  logic        id_rw, id_mr;
  logic [5:0]  id_ctrl;
  logic [31:0] id_d1, id_d2, id_imm;

  logic [31:0] a_rs, a_rt, a_rd, a_d1, a_d2, a_imm;
  logic        a_rw, a_mr, a_pcw, a_ifw, a_stall;
  logic [5:0]  a_ctrl;
  logic [31:0] b_rs, b_rt, b_rd, b_d1, b_d2, b_imm;
  logic        b_rw, b_mr, b_pcw, b_ifw, b_stall;
  logic [5:0]  b_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.REG_ADDR_W(32), .DATA_W(32), .LOAD_USE_BUBBLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .EX_Flush(EX_Flush),
    .IF_ID_Reg_Rs(id_rs), .IF_ID_Reg_Rt(id_rt), .ID_Reg_Rd(id_rd),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Ctrl(id_ctrl),
    .ID_Read_Data1(id_d1), .ID_Read_Data2(id_d2), .ID_Imm(id_imm),
    .ID_EX_Reg_Rs(a_rs), .ID_EX_Reg_Rt(a_rt), .ID_EX_Reg_Rd(a_rd),
    .ID_EX_RegWrite(a_rw), .ID_EX_MemRead(a_mr), .ID_EX_Ctrl(a_ctrl),
    .ID_EX_Read_Data1(a_d1), .ID_EX_Read_Data2(a_d2), .ID_EX_Imm(a_imm),
    .PC_Write(a_pcw), .IF_ID_Write(a_ifw), .Hazard_Stall(a_stall)
  );

  id_ex_hazard_stage #(.REG_ADDR_W(32), .DATA_W(32), .LOAD_USE_BUBBLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .EX_Flush(EX_Flush),
    .IF_ID_Reg_Rs(id_rs), .IF_ID_Reg_Rt(id_rt), .ID_Reg_Rd(id_rd),
    .ID_RegWrite(id_rw), .ID_MemRead(id_mr), .ID_Ctrl(id_ctrl),
    .ID_Read_Data1(id_d1), .ID_Read_Data2(id_d2), .ID_Imm(id_imm),
    .ID_EX_Reg_Rs(b_rs), .ID_EX_Reg_Rt(b_rt), .ID_EX_Reg_Rd(b_rd),
    .ID_EX_RegWrite(b_rw), .ID_EX_MemRead(b_mr), .ID_EX_Ctrl(b_ctrl),
    .ID_EX_Read_Data1(b_d1), .ID_EX_Read_Data2(b_d2), .ID_EX_Imm(b_imm),
    .PC_Write(b_pcw), .IF_ID_Write(b_ifw), .Hazard_Stall(b_stall)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] rs, rt, rd;
    logic        rw, mr;
    logic [5:0]  ctrl;
    logic [31:0] d1, d2, imm;
  } ex_t;

  ex_t m_ex  [2];
  int  m_rem [2];
  int  m_n   [2] = '{1, 3};
  bit  m_valid = 1'b0;

  function automatic ex_t id_fields();
    return {id_rs, id_rt, id_rd, id_rw, id_mr, id_ctrl, id_d1, id_d2, id_imm};
  endfunction

  // True when the load held in EX writes a nonzero register that ID reads.
  function automatic bit m_hazard(int k);
    return m_ex[k].mr && (m_ex[k].rt != 32'd0) &&
           ((m_ex[k].rt == id_rs) || (m_ex[k].rt == id_rt));
  endfunction

  function automatic logic [202:0] m_expect(int k);
    bit st;
    st = rst_n && !EX_Flush && ((m_rem[k] > 0) || m_hazard(k));
    return {m_ex[k], !st, !st, st};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || EX_Flush) begin
        m_ex[k]  <= '0;
        m_rem[k] <= 0;
      end else if (m_rem[k] > 0) begin
        m_ex[k]  <= '0;
        m_rem[k] <= m_rem[k] - 1;
      end else if (m_hazard(k)) begin
        m_ex[k]  <= '0;
        m_rem[k] <= m_n[k] - 1;
      end else begin
        m_ex[k]  <= id_fields();
        m_rem[k] <= 0;
      end
    end
    if (!rst_n) m_valid <= 1'b1;
  end

  wire [202:0] a_obs = {a_rs, a_rt, a_rd, a_rw, a_mr, a_ctrl, a_d1, a_d2, a_imm, a_pcw, a_ifw, a_stall};
  wire [202:0] b_obs = {b_rs, b_rt, b_rd, b_rw, b_mr, b_ctrl, b_d1, b_d2, b_imm, b_pcw, b_ifw, b_stall};

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [202:0] obs, exp_v;
        obs   = (k == 0) ? a_obs : b_obs;
        exp_v = m_expect(k);
        checks++;
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", k, $time, obs, exp_v);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] rs_v, input logic [31:0] rt_v, input logic [31:0] rd_v,
                           input logic rw_v, input logic mr_v, input logic [31:0] dat);
    id_rs   = rs_v;
    id_rt   = rt_v;
    id_rd   = rd_v;
    id_rw   = rw_v;
    id_mr   = mr_v;
    id_ctrl = rd_v[5:0];
    id_d1   = dat;
    id_d2   = ~dat;
    id_imm  = dat + 32'd1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    EX_Flush = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    EX_Flush = 1'b0;
    set_instr(32'd3, 32'd4, 32'd5, 1'b1, 1'b1, 32'hDEAD_BEEF);

    // Reset held for two edges.
    tick();
    tick();
    mid();
    chk("rst_pcw",   {31'd0, a_pcw},   32'd1);
    chk("rst_ifw",   {31'd0, a_ifw},   32'd1);
    chk("rst_stall", {31'd0, b_stall}, 32'd0);
    chk("rst_rd",    a_rd,             32'd0);
    chk("rst_d1",    b_d1,             32'd0);

    // Load-use with a single bubble.
    do_reset();
    set_instr(32'd3, 32'd8, 32'd8, 1'b1, 1'b1, 32'h0000_0080);
    tick();
    set_instr(32'd8, 32'd9, 32'd10, 1'b1, 1'b0, 32'h0000_00A0);
    mid();
    chk("lu_stall", {31'd0, a_stall}, 32'd1);
    chk("lu_pcw",   {31'd0, a_pcw},   32'd0);
    chk("lu_ifw",   {31'd0, a_ifw},   32'd0);
    tick();
    chk("lu_bub_rw", {31'd0, a_rw}, 32'd0);
    chk("lu_bub_mr", {31'd0, a_mr}, 32'd0);
    mid();
    chk("lu_clear", {31'd0, a_stall}, 32'd0);
    tick();
    chk("lu_cap_rs", a_rs, 32'd8);
    chk("lu_cap_rd", a_rd, 32'd10);

    // A load to register 0 never stalls.
    do_reset();
    set_instr(32'd2, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_0002);
    tick();
    set_instr(32'd0, 32'd0, 32'd4, 1'b1, 1'b0, 32'h0000_0011);
    mid();
    chk("r0_stall_a", {31'd0, a_stall}, 32'd0);
    chk("r0_stall_b", {31'd0, b_stall}, 32'd0);
    tick();
    chk("r0_cap_rd", a_rd, 32'd4);
    chk("r0_cap_d1", a_d1, 32'h0000_0011);

    // Three bubbles on the N=3 instance.
    do_reset();
    set_instr(32'd1, 32'd5, 32'd5, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    set_instr(32'd1, 32'd5, 32'd6, 1'b1, 1'b0, 32'h0000_0066);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("n3_stall", {31'd0, b_stall}, 32'd1);
      tick();
      chk("n3_bub_rw", {31'd0, b_rw}, 32'd0);
      chk("n3_bub_rd", b_rd, 32'd0);
    end
    mid();
    chk("n3_release", {31'd0, b_stall}, 32'd0);
    tick();
    chk("n3_cap_rd", b_rd, 32'd6);

    // A flush in the same cycle as a hazard.
    do_reset();
    set_instr(32'd2, 32'd7, 32'd7, 1'b1, 1'b1, 32'h0000_0077);
    tick();
    set_instr(32'd7, 32'd3, 32'd9, 1'b1, 1'b0, 32'h0000_0099);
    EX_Flush = 1'b1;
    mid();
    chk("fl_pcw",     {31'd0, a_pcw},   32'd1);
    chk("fl_stall_a", {31'd0, a_stall}, 32'd0);
    chk("fl_stall_b", {31'd0, b_stall}, 32'd0);
    tick();
    chk("fl_bub_rd_a", a_rd,           32'd0);
    chk("fl_bub_rw_a", {31'd0, a_rw},  32'd0);
    chk("fl_bub_rd_b", b_rd,           32'd0);
    EX_Flush = 1'b0;
    set_instr(32'd4, 32'd4, 32'd11, 1'b1, 1'b0, 32'h0000_00BB);
    mid();
    chk("fl_run_a", {31'd0, a_stall}, 32'd0);
    chk("fl_run_b", {31'd0, b_stall}, 32'd0);
    tick();
    chk("fl_cap_a", a_rd, 32'd11);
    chk("fl_cap_b", b_rd, 32'd11);

    // Reset in the middle of a three-bubble stall.
    do_reset();
    set_instr(32'd2, 32'd5, 32'd5, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    set_instr(32'd5, 32'd1, 32'd12, 1'b1, 1'b0, 32'h0000_00CC);
    mid();
    chk("mr_stall", {31'd0, b_stall}, 32'd1);
    tick();
    chk("mr_bub_rd", b_rd, 32'd0);
    rst_n = 1'b0;
    mid();
    chk("mr_rst_stall", {31'd0, b_stall}, 32'd0);
    chk("mr_rst_pcw",   {31'd0, b_pcw},   32'd1);
    tick();
    chk("mr_rst_rd", b_rd,          32'd0);
    chk("mr_rst_mr", {31'd0, b_mr}, 32'd0);
    rst_n = 1'b1;
    mid();
    chk("mr_after_stall", {31'd0, b_stall}, 32'd0);
    tick();
    chk("mr_after_cap", b_rd, 32'd12);

    // Mixed traffic on a small register space, checked by the model only.
    for (int c = 0; c < 300; c++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      EX_Flush = ($urandom_range(0, 9) == 0);
      set_instr(32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      tick();
    end
    rst_n    = 1'b1;
    EX_Flush = 1'b0;
    tick();
    tick();
    mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
